// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 slave register bank: FSM state encoding,
// slave-error causes, PPROT bit positions and the byte-offset helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    SETUP_CHK = 2'd2
  } apb_state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_RANGE = 3'd1,
    ERR_ALIGN = 3'd2,
    ERR_RO    = 3'd3,
    ERR_PROT  = 3'd4
  } apb_err_e;

  // PPROT bit positions
  localparam int PPROT_PRIV   = 0;
  localparam int PPROT_NSEC   = 1;
  localparam int PPROT_INSTR  = 2;

  // Width of the wait-state counter (WAIT_STATES is limited to 0..15)
  localparam int WAIT_CNT_W = 4;

  // Number of byte-offset address bits for a given data width
  function automatic int apb_lsb(input int data_w);
    return (data_w == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/apb_slv_wait_ctrl.sv
// APB4 transfer sequencer: tracks setup/access phases, counts wait states,
// and produces pready plus the capture and abort strobes for the register bank.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transfer; a setup phase (psel & !penable) starts one
// ACCESS    | access phase; pready once the wait count is reached
// SETUP_CHK | cycle after a completion; behaves like IDLE (back-to-back)
module apb_slv_wait_ctrl
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic capture,
  output logic abort
);

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_ACCESS    = ACCESS;
  localparam logic [1:0] S_SETUP_CHK = SETUP_CHK;
  localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

  logic [1:0]            state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;

  assign pready  = (state == S_ACCESS) && (cnt == WS) && psel && penable;
  assign capture = (state != S_ACCESS) && psel && !penable;
  assign abort   = (state == S_ACCESS) && !psel;

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_ACCESS: begin
        if (!psel) begin
          state_nxt = S_IDLE;
        end else if (pready) begin
          state_nxt = S_SETUP_CHK;
        end else if (cnt != WS) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        if (capture) begin
          state_nxt = S_ACCESS;
          cnt_nxt   = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/apb4_slave_regbank.sv
// Parametrised APB4 slave with an integrated register bank: byte-strobed
// writes, read-only slots backed by hw_rd_data, slave-error decode and
// per-register access pulses.
// Optional: define APB_PROT_CHECK_EN to reject unprivileged writes
// (pprot[0]=0) with pslverr; when undefined pprot is ignored.
module apb4_slave_regbank
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W/8-1:0]        pstrb,
  input  logic [2:0]                 pprot,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  input  logic [NUM_REGS*DATA_W-1:0] hw_rd_data,
  output logic [NUM_REGS-1:0]        wr_pulse,
  output logic [NUM_REGS-1:0]        rd_pulse
);

  localparam int LSB    = apb_lsb(DATA_W);
  localparam int NB     = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                capture, abort;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_write;
  logic [DATA_W-1:0]   cap_wdata;
  logic [NB-1:0]       cap_strb;
  logic [IDX_W-1:0]    idx;
  logic [RIDX_W-1:0]   ridx;
  logic                out_range;
  apb_err_e            err_code;
  logic                err;
  logic                commit_wr;
  logic                rd_ok;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                unused_prot;

  apb_slv_wait_ctrl #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_ctrl (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pready  (pready),
    .capture (capture),
    .abort   (abort)
  );

  // Setup-phase capture of address and control; bus changes during the
  // access phase are deliberately not sampled
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else if (capture) begin
      cap_addr  <= paddr;
      cap_write <= pwrite;
      cap_wdata <= pwdata;
      cap_strb  <= pstrb;
    end else if (abort) begin
      cap_write <= 1'b0;
    end
  end

`ifdef APB_PROT_CHECK_EN
  logic cap_priv;

  // Privilege attribute of the captured transfer
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cap_priv <= 1'b0;
    end else if (capture) begin
      cap_priv <= pprot[PPROT_PRIV];
    end
  end
`endif

  // Only pprot[0] matters, and only when the privilege check is built in
  assign unused_prot = ^pprot;

  assign idx       = cap_addr[ADDR_W-1:LSB];
  assign ridx      = idx[RIDX_W-1:0];
  assign out_range = (idx >= IDX_W'(NUM_REGS));

  // Error decode on the captured transfer, alignment first
  always_comb begin
    err_code = ERR_NONE;
    if (cap_addr[LSB-1:0] != '0) begin
      err_code = ERR_ALIGN;
    end else if (out_range) begin
      err_code = ERR_RANGE;
    end else if (cap_write && RO_MASK[ridx]) begin
      err_code = ERR_RO;
    end
`ifdef APB_PROT_CHECK_EN
    else if (cap_write && !cap_priv) begin
      err_code = ERR_PROT;
    end
`endif
  end

  assign err       = (err_code != ERR_NONE);
  assign pslverr   = err && pready;
  assign commit_wr = pready && cap_write && !err;
  assign rd_ok     = pready && !cap_write && !err;

  // Single-cycle access pulses in the completing cycle
  always_comb begin
    wr_pulse = '0;
    rd_pulse = '0;
    if (commit_wr) wr_pulse[ridx] = 1'b1;
    if (rd_ok)     rd_pulse[ridx] = 1'b1;
  end

  // Read mux: RO slots return hardware status, others the stored value
  always_comb begin
    prdata = '0;
    if (rd_ok) begin
      if (RO_MASK[ridx]) begin
        prdata = hw_rd_data[ridx*DATA_W +: DATA_W];
      end else begin
        prdata = regs[ridx];
      end
    end
  end

  // Register storage with per-byte write enables; RO slots hold zero
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_W +: DATA_W];
      end
    end else if (commit_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (cap_strb[b]) begin
          regs[ridx][b*8 +: 8] <= cap_wdata[b*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Self-checking bench for apb4_slave_regbank: two instances (0 and 3 wait
// states) share the bus; expected completions are queued when a transfer is
// issued and compared when the DUT raises pready.
module tb_apb4_slave_regbank;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam logic [NR-1:0] ROM = 8'b0000_1000;
  localparam logic [NR*DW-1:0] RV = {32'h7777_0007, 32'h6666_0006,
                                     32'h5555_0005, 32'h4444_0004,
                                     32'hFFFF_FFFF, 32'h2222_0002,
                                     32'h1111_0001, 32'hCAFE_F00D};

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic [NR-1:0] wp;
    logic [NR-1:0] rp;
  } exp_t;

  logic              pclk = 1'b0;
  logic              preset;
  logic [1:0]        psel, penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [DW-1:0]     prdata [2];
  logic [1:0]        pready, pslverr;
  logic [NR*DW-1:0]  reg_q [2];
  logic [NR*DW-1:0]  hw;
  logic [NR-1:0]     wr_pulse [2];
  logic [NR-1:0]     rd_pulse [2];

  logic [DW-1:0]     model [2][NR];
  logic [NR*DW-1:0]  rv_v;
  logic [NR-1:0]     rom_v;
  exp_t              sb[$];
  int                cur;
  int                checks = 0;
  int                errors = 0;

  always #5 pclk = ~pclk;

  apb4_slave_regbank #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(0),
    .RO_MASK(ROM), .RESET_VAL(RV)
  ) u_dut_w0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .reg_q(reg_q[0]), .hw_rd_data(hw),
    .wr_pulse(wr_pulse[0]), .rd_pulse(rd_pulse[0])
  );

  apb4_slave_regbank #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(3),
    .RO_MASK(ROM), .RESET_VAL(RV)
  ) u_dut_w3 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .reg_q(reg_q[1]), .hw_rd_data(hw),
    .wr_pulse(wr_pulse[1]), .rd_pulse(rd_pulse[1])
  );

  task automatic chk(input string tag, input logic [NR*DW-1:0] got,
                     input logic [NR*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++)
        model[d][i] = rom_v[i] ? '0 : rv_v[i*DW +: DW];
  endtask

  function automatic logic [NR*DW-1:0] pack(input int d);
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[d][i];
    return v;
  endfunction

  // Scoreboard consumer: compare at every pready, require quiet outputs otherwise
  always @(negedge pclk) begin
    exp_t e;
    if (pready[cur]) begin
      chk("sb_nonempty", NR*DW'(sb.size() != 0), NR*DW'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("prdata",   NR*DW'(prdata[cur]),   NR*DW'(e.rdata));
        chk("pslverr",  NR*DW'(pslverr[cur]),  NR*DW'(e.err));
        chk("wr_pulse", NR*DW'(wr_pulse[cur]), NR*DW'(e.wp));
        chk("rd_pulse", NR*DW'(rd_pulse[cur]), NR*DW'(e.rp));
      end
    end else begin
      chk("idle_prdata",  NR*DW'(prdata[cur]),   '0);
      chk("idle_pslverr", NR*DW'(pslverr[cur]),  '0);
      chk("idle_wr_pulse", NR*DW'(wr_pulse[cur]), '0);
      chk("idle_rd_pulse", NR*DW'(rd_pulse[cur]), '0);
    end
  end

  task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [3:0] st,
                      input logic [2:0] pr);
    exp_t e;
    int   idx;
    logic err;
    int   lat;
    idx = int'(a[AW-1:2]);
    err = (a[1:0] != 2'b00) || (idx >= NR);
    if (!err && wr && rom_v[idx]) err = 1'b1;
`ifdef APB_PROT_CHECK_EN
    if (wr && !pr[0]) err = 1'b1;
`endif
    e = '0;
    e.err = err;
    if (!err) begin
      if (wr) begin
        e.wp[idx] = 1'b1;
        for (int b = 0; b < 4; b++)
          if (st[b]) model[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        e.rp[idx] = 1'b1;
        e.rdata = rom_v[idx] ? hw[idx*DW +: DW] : model[d][idx];
      end
    end
    sb.push_back(e);
    cur = d;
    @(posedge pclk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    // scramble the bus: the DUT must use the values captured at setup
    pwrite = ~wr; paddr = ~a; pwdata = ~wd; pstrb = ~st;
    lat = 1;
    forever begin
      @(negedge pclk);
      if (pready[d] || lat > 20) break;
      lat++;
    end
    chk("latency", NR*DW'(lat), NR*DW'((d == 0) ? 1 : 4));
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    #1;
    chk("reg_q", reg_q[d], pack(d));
  endtask

  initial begin
    preset = 1'b1; psel = '0; penable = '0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0; cur = 0;
    rv_v = RV; rom_v = ROM;
    for (int i = 0; i < NR; i++) hw[i*DW +: DW] = 32'hB0B0_0000 | DW'(i);
    hw[3*DW +: DW] = 32'h0000_005A;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_reg_q0", reg_q[0], pack(0));
    chk("rst_reg_q1", reg_q[1], pack(1));
    chk("rst_pready", NR*DW'(pready), '0);
    preset = 1'b0;

    // basic write/read, zero wait states
    xfer(0, 1'b1, 12'h004, 32'hDEAD_BEEF, 4'hF, 3'b001);
    xfer(0, 1'b0, 12'h004, 32'h0,         4'h0, 3'b001);
    // three wait states, reset value readback
    xfer(1, 1'b0, 12'h000, 32'h0,         4'h0, 3'b001);
    // byte strobes
    xfer(1, 1'b1, 12'h008, 32'h1122_3344, 4'hF, 3'b001);
    xfer(1, 1'b1, 12'h008, 32'hAABB_CCDD, 4'b0101, 3'b001);
    xfer(1, 1'b0, 12'h008, 32'h0,         4'h0, 3'b001);
    // errors: range, alignment, read-only, then RO readback
    xfer(0, 1'b0, 12'h020, 32'h0,         4'h0, 3'b001);
    xfer(0, 1'b1, 12'h006, 32'h1234_5678, 4'hF, 3'b001);
    xfer(0, 1'b1, 12'h00C, 32'h9999_9999, 4'hF, 3'b001);
    xfer(0, 1'b0, 12'h00C, 32'h0,         4'h0, 3'b001);
    xfer(0, 1'b1, 12'hFFC, 32'h0BAD_0BAD, 4'hF, 3'b001);
    // zero strobes: pulse but no change
    xfer(0, 1'b1, 12'h010, 32'hFFFF_FFFF, 4'h0, 3'b001);
    xfer(0, 1'b0, 12'h010, 32'h0,         4'h0, 3'b001);
    // protection attribute
    xfer(0, 1'b1, 12'h014, 32'h0000_0055, 4'hF, 3'b000);
    xfer(0, 1'b0, 12'h014, 32'h0,         4'h0, 3'b000);
    xfer(0, 1'b1, 12'h014, 32'h0000_0066, 4'hF, 3'b001);
    xfer(0, 1'b0, 12'h014, 32'h0,         4'h0, 3'b000);

    // penable without a setup phase is ignored
    cur = 0;
    @(posedge pclk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite = 1'b1; paddr = 12'h018;
    pwdata = 32'h1357_9BDF; pstrb = 4'hF; pprot = 3'b001;
    repeat (2) @(posedge pclk);
    #1;
    chk("idle_penable_pready", NR*DW'(pready[0]), '0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    #1;
    chk("idle_penable_reg_q", reg_q[0], pack(0));

    // psel dropped mid-access: no commit
    cur = 1;
    @(posedge pclk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite = 1'b1; paddr = 12'h014;
    pwdata = 32'h1234_5678; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (5) @(posedge pclk);
    #1;
    chk("abort_reg_q", reg_q[1], pack(1));

    // reset in the middle of an access
    @(posedge pclk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'h0F0F_0F0F; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    model_reset();
    #1;
    chk("midrst_pready", NR*DW'(pready[1]), '0);
    chk("midrst_reg_q1", reg_q[1], pack(1));
    chk("midrst_reg_q0", reg_q[0], pack(0));
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;

    // normal operation after reset
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, 3'b001);
    xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, 3'b001);

    repeat (2) @(posedge pclk);
    chk("sb_drained", NR*DW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
